// File: rtl/control_pipe_pkg.sv
// Shared widths, control-word field positions and stage-register type for control_pipe.
package control_pipe_pkg;

    localparam int CW_W = 10;
    localparam int RA_W = 5;

    localparam int CW_PCSEL_HI = 9;
    localparam int CW_PCSEL_LO = 8;
    localparam int CW_ORIGALU  = 7;
    localparam int CW_ALUOP_HI = 6;
    localparam int CW_ALUOP_LO = 4;
    localparam int CW_MEMWRITE = 3;
    localparam int CW_MEMREAD  = 2;
    localparam int CW_REGWRITE = 1;
    localparam int CW_MEMTOREG = 0;

    localparam logic [1:0] PC4   = 2'b00;
    localparam logic [1:0] PCBEQ = 2'b01;
    localparam logic [1:0] PCIMM = 2'b10;

    localparam logic [CW_W-1:0] CTRL_BUBBLE = '0;

    typedef struct packed {
        logic [CW_W-1:0] cw;
        logic [RA_W-1:0] rd;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{cw: CTRL_BUBBLE, rd: '0};

endpackage

// File: rtl/control_pipe_stage_reg.sv
// One pipeline stage of control word plus rd: async clear, synchronous bubble load.
module ctrl_stage_reg
    import control_pipe_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   bubble_i,
    input  stage_t data_i,
    output stage_t data_o
);

    stage_t stage_d;
    stage_t stage_q;

    assign stage_d = bubble_i ? STAGE_BUBBLE : data_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q <= STAGE_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q;

endmodule

// File: rtl/control_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with redirect flush.
// Optional load-use stall detection is built when CTRL_PIPE_LOADUSE_EN is defined.
module control_pipe
    import control_pipe_pkg::*;
(
    input  logic            iCLK,
    input  logic            iRST_n,
    input  logic [CW_W-1:0] iControl,
    input  logic            iValid,
    input  logic [RA_W-1:0] iRs1,
    input  logic [RA_W-1:0] iRs2,
    input  logic [RA_W-1:0] iRd,
    input  logic            iRedirect,
    output logic            oStall,
    output logic            oFlushIFID,
    output logic [1:0]      oExPcSel,
    output logic            oExOrigAlu,
    output logic [2:0]      oExAluOp,
    output logic            oMemWrite,
    output logic            oMemRead,
    output logic            oWbRegWrite,
    output logic            oWbMemtoReg,
    output logic [RA_W-1:0] oWbRd
);

    stage_t idex_d;
    stage_t idex_q;
    stage_t exmem_q;
    stage_t memwb_q;
    logic   idex_bubble;
    logic   stall;

`ifdef CTRL_PIPE_LOADUSE_EN
    logic rd_match;

    // Both sources are compared even if the instruction ignores them.
    assign rd_match = (idex_q.rd == iRs1) || (idex_q.rd == iRs2);
    assign stall    = idex_q.cw[CW_MEMREAD] & idex_q.cw[CW_REGWRITE]
                    & (idex_q.rd != '0) & rd_match & iValid;
`else
    logic unused_srcs;

    assign unused_srcs = ^{iRs1, iRs2, idex_q.rd};
    assign stall       = 1'b0;
`endif

    assign idex_d      = '{cw: iControl, rd: iRd};
    assign idex_bubble = iRedirect | stall | ~iValid;

    ctrl_stage_reg u_idex (
        .clk_i    (iCLK),
        .rst_n_i  (iRST_n),
        .bubble_i (idex_bubble),
        .data_i   (idex_d),
        .data_o   (idex_q)
    );

    ctrl_stage_reg u_exmem (
        .clk_i    (iCLK),
        .rst_n_i  (iRST_n),
        .bubble_i (1'b0),
        .data_i   (idex_q),
        .data_o   (exmem_q)
    );

    ctrl_stage_reg u_memwb (
        .clk_i    (iCLK),
        .rst_n_i  (iRST_n),
        .bubble_i (1'b0),
        .data_i   (exmem_q),
        .data_o   (memwb_q)
    );

    logic unused_fields;
    assign unused_fields = ^{exmem_q.cw[CW_PCSEL_HI:CW_ALUOP_LO], exmem_q.cw[CW_REGWRITE:CW_MEMTOREG],
                             exmem_q.rd, memwb_q.cw[CW_PCSEL_HI:CW_MEMREAD]};

    assign oStall      = stall;
    assign oFlushIFID  = iRedirect;
    assign oExPcSel    = idex_q.cw[CW_PCSEL_HI:CW_PCSEL_LO];
    assign oExOrigAlu  = idex_q.cw[CW_ORIGALU];
    assign oExAluOp    = idex_q.cw[CW_ALUOP_HI:CW_ALUOP_LO];
    assign oMemWrite   = exmem_q.cw[CW_MEMWRITE];
    assign oMemRead    = exmem_q.cw[CW_MEMREAD];
    assign oWbRegWrite = memwb_q.cw[CW_REGWRITE];
    assign oWbMemtoReg = memwb_q.cw[CW_MEMTOREG];
    assign oWbRd       = memwb_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: expected stage contents are queued as words are issued.
module tb_control_pipe;

`ifdef CTRL_PIPE_LOADUSE_EN
    localparam logic LU = 1'b1;
`else
    localparam logic LU = 1'b0;
`endif

    localparam logic [9:0] W_LOAD  = 10'b00_1_000_0_1_1_1;
    localparam logic [9:0] W_ADD   = 10'b00_0_010_0_0_1_0;
    localparam logic [9:0] W_STORE = 10'b00_1_000_1_0_0_0;
    localparam logic [9:0] W_BEQ   = 10'b01_0_001_0_0_0_0;
    localparam logic [9:0] W_JAL   = 10'b10_1_000_0_0_1_0;

    typedef struct packed {
        logic [9:0] cw;
        logic [4:0] rd;
    } ent_t;

    logic       iCLK = 1'b0;
    logic       iRST_n;
    logic [9:0] iControl;
    logic       iValid;
    logic [4:0] iRs1, iRs2, iRd;
    logic       iRedirect;
    logic       oStall, oFlushIFID;
    logic [1:0] oExPcSel;
    logic       oExOrigAlu;
    logic [2:0] oExAluOp;
    logic       oMemWrite, oMemRead;
    logic       oWbRegWrite, oWbMemtoReg;
    logic [4:0] oWbRd;

    int   n_checks = 0;
    int   n_fails  = 0;
    ent_t pipe_q[$];

    control_pipe dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iControl    (iControl),
        .iValid      (iValid),
        .iRs1        (iRs1),
        .iRs2        (iRs2),
        .iRd         (iRd),
        .iRedirect   (iRedirect),
        .oStall      (oStall),
        .oFlushIFID  (oFlushIFID),
        .oExPcSel    (oExPcSel),
        .oExOrigAlu  (oExOrigAlu),
        .oExAluOp    (oExAluOp),
        .oMemWrite   (oMemWrite),
        .oMemRead    (oMemRead),
        .oWbRegWrite (oWbRegWrite),
        .oWbMemtoReg (oWbMemtoReg),
        .oWbRd       (oWbRd)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_queue();
        pipe_q.delete();
        for (int i = 0; i < 3; i++) pipe_q.push_front('0);
    endtask

    task automatic check_stages(input string tag);
        ent_t ex, mem, wb;
        ex  = pipe_q[0];
        mem = pipe_q[1];
        wb  = pipe_q[2];
        chk({tag, ".ex"},  {26'd0, oExPcSel, oExOrigAlu, oExAluOp}, {26'd0, ex.cw[9:4]});
        chk({tag, ".mem"}, {30'd0, oMemWrite, oMemRead}, {30'd0, mem.cw[3:2]});
        chk({tag, ".wb"},  {25'd0, oWbRegWrite, oWbMemtoReg, oWbRd}, {25'd0, wb.cw[1:0], wb.rd});
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic step(input logic [9:0] c, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic redir, input logic exp_stall, input string tag);
        ent_t e;
        iControl  = c;
        iValid    = v;
        iRs1      = r1;
        iRs2      = r2;
        iRd       = rd;
        iRedirect = redir;
        #2;
        chk({tag, ".stall"}, {31'd0, oStall}, {31'd0, exp_stall});
        chk({tag, ".flush"}, {31'd0, oFlushIFID}, {31'd0, redir});
        e = (redir || exp_stall || !v) ? ent_t'('0) : ent_t'({c, rd});
        @(posedge iCLK);
        pipe_q.push_front(e);
        void'(pipe_q.pop_back());
        #1;
        check_stages(tag);
    endtask

    task automatic idle(input string tag);
        step(10'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        iRST_n = 1'b0; iControl = '0; iValid = 1'b0;
        iRs1 = '0; iRs2 = '0; iRd = '0; iRedirect = 1'b0;
        reset_queue();
        #3;
        chk("por.stall", {31'd0, oStall}, 32'd0);
        check_stages("por");
        @(posedge iCLK); #1;
        iRST_n = 1'b1;
        @(posedge iCLK); #1;

        // Flow: LOAD walks EX -> MEM -> WB.
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, "flow0");
        chk("flow.origalu", {31'd0, oExOrigAlu}, 32'd1);
        idle("flow1");
        chk("flow.memread", {31'd0, oMemRead}, 32'd1);
        idle("flow2");
        chk("flow.wb", {25'd0, oWbRegWrite, oWbMemtoReg, oWbRd}, {25'd0, 2'b11, 5'd5});
        idle("flow3");

        // Load-use on rs1: stalled ADD is re-presented from the held IF/ID.
        step(W_LOAD, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, "lu.ld");
        step(W_ADD,  1'b1, 5'd5, 5'd0, 5'd6, 1'b0, LU,   "lu.add");
        step(W_ADD,  1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, "lu.add2");
        // Load-use on rs2.
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, "lu2.ld");
        step(W_ADD,  1'b1, 5'd3, 5'd9, 5'd4, 1'b0, LU,   "lu2.add");
        step(W_ADD,  1'b1, 5'd3, 5'd9, 5'd4, 1'b0, 1'b0, "lu2.add2");

        // No hazard: rd = 0, and non-matching sources.
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "nh.ld0");
        step(W_ADD,  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "nh.add0");
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, "nh.ld5");
        step(W_ADD,  1'b1, 5'd6, 5'd7, 5'd8, 1'b0, 1'b0, "nh.add");
        idle("nh.d0");
        idle("nh.d1");

        // Redirect with a valid ADD in ID; STORE and LOAD ahead of it complete.
        step(W_STORE, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "rd.st");
        step(W_LOAD,  1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, "rd.ld");
        step(W_ADD,   1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, "rd.add");
        step(W_BEQ,   1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, "rd.beq");
        idle("rd.d0");
        idle("rd.d1");

        // Redirect and load-use together, then normal acceptance.
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, "sim.ld");
        step(W_ADD,  1'b1, 5'd5, 5'd0, 5'd6, 1'b1, LU,   "sim.add");
        step(W_JAL,  1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0, "sim.jal");
        step(W_ADD,  1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, "sim.x0");
        idle("sim.d0");
        idle("sim.d1");

        // Mid-stream reset with LOADs in every stage.
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0, "rst.l0");
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, "rst.l1");
        step(W_LOAD, 1'b1, 5'd0, 5'd0, 5'd13, 1'b0, 1'b0, "rst.l2");
        iValid = 1'b0;
        iControl = '0;
        iRST_n = 1'b0;
        reset_queue();
        #1;
        chk("rst.stall", {31'd0, oStall}, 32'd0);
        check_stages("rst.async");
        @(posedge iCLK); #1;
        iRST_n = 1'b1;
        idle("rst.r0");
        idle("rst.r1");
        idle("rst.r2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
